// File: rtl/snow64_bfloat16_vec_fpu_sequencer.sv
// snow64_bfloat16_vec_fpu_sequencer: runs one vector command through a scalar bfloat16 FPU, lane 0 first.
// Define SNOW64_BFLOAT16_VEC_FPU_LANE_MASK_EN to add in_lane_mask; masked-off lanes pass in_a through.
module snow64_bfloat16_vec_fpu_sequencer #(
    parameter int NUM_LANES  = 16,
    parameter int WIDTH_OPER = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_start,
    input  logic [WIDTH_OPER-1:0]   in_oper,
    input  logic [16*NUM_LANES-1:0] in_a,
    input  logic [16*NUM_LANES-1:0] in_b,
`ifdef SNOW64_BFLOAT16_VEC_FPU_LANE_MASK_EN
    input  logic [NUM_LANES-1:0]    in_lane_mask,
`endif
    output logic                    out_can_accept_cmd,
    output logic                    out_data_valid,
    output logic [16*NUM_LANES-1:0] out_data,
    output logic                    out_fpu_start,
    output logic [WIDTH_OPER-1:0]   out_fpu_oper,
    output logic [15:0]             out_fpu_a,
    output logic [15:0]             out_fpu_b,
    input  logic                    in_fpu_data_valid,
    input  logic                    in_fpu_can_accept_cmd,
    input  logic [15:0]             in_fpu_data
);
    localparam int LW = $clog2(NUM_LANES);
    localparam logic [LW-1:0] LAST = LW'(NUM_LANES - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_t;

    state_t                  r_state, w_next;
    logic [WIDTH_OPER-1:0]   r_oper;
    logic [16*NUM_LANES-1:0] r_a, r_b, r_data;
    logic [LW-1:0]           r_lane;
    logic                    w_last, w_skip;
    logic [15:0]             w_lane_a, w_lane_b;

    assign w_last   = r_lane == LAST;
    assign w_lane_a = r_a[{r_lane, 4'd0} +: 16];
    assign w_lane_b = r_b[{r_lane, 4'd0} +: 16];

`ifdef SNOW64_BFLOAT16_VEC_FPU_LANE_MASK_EN
    logic [NUM_LANES-1:0] r_mask;
    assign w_skip = ~r_mask[r_lane];
`else
    assign w_skip = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= StIdle;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            StIdle:  w_next = in_start ? StIssue : StIdle;
            StIssue: w_next = w_skip ? (w_last ? StDone : StIssue)
                                     : (in_fpu_can_accept_cmd ? StWait : StIssue);
            StWait:  w_next = in_fpu_data_valid ? (w_last ? StDone : StIssue) : StWait;
            default: w_next = StIdle;
        endcase
    end

    always_comb begin
        out_can_accept_cmd = r_state == StIdle;
        out_data_valid     = r_state == StDone;
        out_data           = r_data;
        out_fpu_start      = (r_state == StIssue) && in_fpu_can_accept_cmd && !w_skip;
        out_fpu_oper       = r_oper;
        out_fpu_a          = w_lane_a;
        out_fpu_b          = w_lane_b;
    end

    // Lane results land in place; the counter stops at the last lane so it never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_oper <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_data <= '0;
            r_lane <= '0;
`ifdef SNOW64_BFLOAT16_VEC_FPU_LANE_MASK_EN
            r_mask <= '0;
`endif
        end else begin
            case (r_state)
                StIdle: if (in_start) begin
                    r_oper <= in_oper;
                    r_a    <= in_a;
                    r_b    <= in_b;
                    r_data <= '0;
                    r_lane <= '0;
`ifdef SNOW64_BFLOAT16_VEC_FPU_LANE_MASK_EN
                    r_mask <= in_lane_mask;
`endif
                end
                StIssue: if (w_skip) begin
                    r_data[{r_lane, 4'd0} +: 16] <= w_lane_a;
                    if (!w_last) r_lane <= r_lane + 1'b1;
                end
                StWait: if (in_fpu_data_valid) begin
                    r_data[{r_lane, 4'd0} +: 16] <= in_fpu_data;
                    if (!w_last) r_lane <= r_lane + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_snow64_bfloat16_vec_fpu_sequencer.sv
// tb_snow64_bfloat16_vec_fpu_sequencer: scoreboard bench with a small latency-modelled scalar FPU.
module tb_snow64_bfloat16_vec_fpu_sequencer;
    localparam int N  = 16;
    localparam int DW = 16 * N;
    localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_SLT = 3'd2, OP_MUL = 3'd3;

    logic          clk = 1'b0, rst = 1'b1;
    logic          in_start = 1'b0;
    logic [2:0]    in_oper = '0;
    logic [DW-1:0] in_a = '0, in_b = '0;
    logic [N-1:0]  in_lane_mask = '1;
    logic          out_can_accept_cmd, out_data_valid, out_fpu_start;
    logic [DW-1:0] out_data;
    logic [2:0]    out_fpu_oper;
    logic [15:0]   out_fpu_a, out_fpu_b;
    logic          fpu_ready = 1'b1, fv = 1'b0;
    logic [15:0]   fd = '0, pend = '0;
    int            cnt = 0;

    int errors = 0, checks = 0, cyc = 0, starts = 0, pulses = 0, pulse_cyc = 0, acc_cyc = 0;
    logic [DW-1:0] sbq[$];

    always #5 clk = ~clk;

    snow64_bfloat16_vec_fpu_sequencer #(.NUM_LANES(N), .WIDTH_OPER(3)) dut (
        .clk(clk), .rst(rst), .in_start(in_start), .in_oper(in_oper), .in_a(in_a), .in_b(in_b),
`ifdef SNOW64_BFLOAT16_VEC_FPU_LANE_MASK_EN
        .in_lane_mask(in_lane_mask),
`endif
        .out_can_accept_cmd(out_can_accept_cmd), .out_data_valid(out_data_valid), .out_data(out_data),
        .out_fpu_start(out_fpu_start), .out_fpu_oper(out_fpu_oper), .out_fpu_a(out_fpu_a),
        .out_fpu_b(out_fpu_b), .in_fpu_data_valid(fv), .in_fpu_can_accept_cmd(fpu_ready),
        .in_fpu_data(fd)
    );

    function automatic logic [15:0] fpu_model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            OP_ADD:  return (a == 16'h3F80 && b == 16'h4000) ? 16'h4040 :
                            (a == 16'h3F80 && b == 16'h3F80) ? 16'h4000 : 16'hFFFF;
            OP_SUB:  return (a == 16'h4040 && b == 16'h3F80) ? 16'h4000 : 16'hFFFF;
            OP_MUL:  return (a == 16'h4000 && b == 16'h4040) ? 16'h40C0 : 16'hFFFF;
            OP_SLT:  return (a < b) ? 16'h0001 : 16'h0000;
            default: return 16'hFFFF;
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] op);
        return (op == OP_SLT) ? 1 : 3;
    endfunction

    function automatic logic [DW-1:0] exp_vec(input logic [2:0] op, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b, input logic [N-1:0] m);
        logic [DW-1:0] e;
        for (int i = 0; i < N; i++)
            e[16*i +: 16] = m[i] ? fpu_model(op, a[16*i +: 16], b[16*i +: 16]) : a[16*i +: 16];
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scalar FPU model: result appears lat_of(op) StWait cycles after an accepted start.
    always @(posedge clk) begin
        fv <= 1'b0;
        if (out_fpu_start) begin
            starts <= starts + 1;
            if (lat_of(out_fpu_oper) == 1) begin
                fv <= 1'b1;
                fd <= fpu_model(out_fpu_oper, out_fpu_a, out_fpu_b);
            end else begin
                pend <= fpu_model(out_fpu_oper, out_fpu_a, out_fpu_b);
                cnt  <= lat_of(out_fpu_oper) - 1;
            end
        end else if (cnt != 0) begin
            cnt <= cnt - 1;
            if (cnt == 1) begin
                fv <= 1'b1;
                fd <= pend;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_data_valid) begin
            logic [DW-1:0] e;
            pulses++;
            pulse_cyc = cyc;
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_pulse got=%h required=no pulse", out_data);
            end else begin
                e = sbq.pop_front();
                if (out_data !== e) begin
                    errors++;
                    $display("FAIL sb_data got=%h required=%h", out_data, e);
                end
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b, input bit hold);
        int t = 0;
        @(negedge clk);
        while (!out_can_accept_cmd && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!out_can_accept_cmd) begin
            errors++;
            checks++;
            $display("FAIL send_ready_timeout got=0 required=1");
        end
        in_oper = op;
        in_a = a;
        in_b = b;
        in_start = 1'b1;
        sbq.push_back(exp_vec(op, a, b, in_lane_mask));
        @(posedge clk);
        #1 acc_cyc = cyc;
        if (!hold) in_start = 1'b0;
    endtask

    task automatic wait_pulse(input string name, input int budget, output int lat);
        int p0 = pulses;
        int t = 0;
        while (pulses == p0 && t < budget) begin
            @(negedge clk);
            #1 t++;
        end
        checks++;
        lat = -1;
        if (pulses == p0) begin
            errors++;
            $display("FAIL %s_timeout got=no pulse required=pulse within %0d cycles", name, budget);
        end else lat = pulse_cyc - acc_cyc;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({out_can_accept_cmd, out_data_valid, out_fpu_start} !== 3'b100) begin
            errors++;
            $display("FAIL reset_flags got=%b required=100", {out_can_accept_cmd, out_data_valid, out_fpu_start});
        end
        checks++;
        if (out_data !== '0) begin
            errors++;
            $display("FAIL reset_data got=%h required=0", out_data);
        end
        checks++;
        if ({out_fpu_oper, out_fpu_a, out_fpu_b} !== '0) begin
            errors++;
            $display("FAIL reset_fpu_bus got=%h required=0", {out_fpu_oper, out_fpu_a, out_fpu_b});
        end
        rst = 1'b0;
    endtask

    task automatic test_add;
        int s0 = starts, p0 = pulses, lat;
        send(OP_ADD, {N{16'h3F80}}, {N{16'h4000}}, 1'b0);
        wait_pulse("add", 400, lat);
        checks++;
        if (starts - s0 !== N) begin
            errors++;
            $display("FAIL add_starts got=%0d required=%0d", starts - s0, N);
        end
        checks++;
        if (lat !== N * (1 + lat_of(OP_ADD))) begin
            errors++;
            $display("FAIL add_latency got=%0d required=%0d", lat, N * (1 + lat_of(OP_ADD)));
        end
        repeat (3) @(negedge clk);
        checks++;
        if (out_data !== {N{16'h4040}} || !out_can_accept_cmd || out_data_valid) begin
            errors++;
            $display("FAIL add_hold got=%h/%b/%b required=%h/1/0", out_data, out_can_accept_cmd, out_data_valid, {N{16'h4040}});
        end
        checks++;
        if (pulses - p0 !== 1) begin
            errors++;
            $display("FAIL add_pulses got=%0d required=1", pulses - p0);
        end
    endtask

    task automatic test_stall;
        int s0 = starts, lat;
        bit ok = 1'b1;
        fork
            send(OP_MUL, {N{16'h4000}}, {N{16'h4040}}, 1'b0);
            begin
                int t = 0;
                while (!(starts == s0 + 3 && fv) && t < 500) begin
                    @(negedge clk);
                    t++;
                end
                fpu_ready = 1'b0;
                repeat (6) begin
                    @(posedge clk);
                    @(negedge clk);
                    if (out_fpu_start !== 1'b0) ok = 1'b0;
                end
                fpu_ready = 1'b1;
            end
        join
        wait_pulse("stall", 400, lat);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL stall_start got=start during stall required=no start");
        end
        checks++;
        if (lat !== N * (1 + lat_of(OP_MUL)) + 5) begin
            errors++;
            $display("FAIL stall_latency got=%0d required=%0d", lat, N * (1 + lat_of(OP_MUL)) + 5);
        end
        checks++;
        if (starts - s0 !== N) begin
            errors++;
            $display("FAIL stall_starts got=%0d required=%0d", starts - s0, N);
        end
    endtask

    task automatic test_back_to_back;
        int s0 = starts, p0 = pulses, t = 0;
        bit ok = 1'b1;
        send(OP_SUB, {N{16'h4040}}, {N{16'h3F80}}, 1'b1);
        in_oper = OP_ADD;
        in_a = {N{16'h3F80}};
        in_b = {N{16'h3F80}};
        while (!out_data_valid && t < 400) begin
            if (out_can_accept_cmd !== 1'b0) ok = 1'b0;
            @(negedge clk);
            #1 t++;
        end
        in_start = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL busy_accept got=1 while busy required=0");
        end
        checks++;
        if (pulses - p0 !== 1 || starts - s0 !== N) begin
            errors++;
            $display("FAIL busy_single got=%0d pulses/%0d starts required=1/%0d", pulses - p0, starts - s0, N);
        end
    endtask

    task automatic test_reset_mid;
        int s0 = starts, p0, t = 0;
        send(OP_ADD, {N{16'h3F80}}, {N{16'h4000}}, 1'b0);
        while (starts != s0 + 8 && t < 400) begin
            @(negedge clk);
            t++;
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_data !== '0 || out_can_accept_cmd !== 1'b1 || out_data_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_state got=%h/%b/%b required=0/1/0", out_data, out_can_accept_cmd, out_data_valid);
        end
        rst = 1'b0;
        void'(sbq.pop_back());
        p0 = pulses;
        repeat (20) @(negedge clk);
        checks++;
        if (pulses !== p0) begin
            errors++;
            $display("FAIL midrst_pulse got=%0d required=0", pulses - p0);
        end
        test_add();
    endtask

    task automatic test_slt;
        logic [DW-1:0] a, b;
        int lat;
        for (int i = 0; i < N; i++) begin
            a[16*i +: 16] = i[0] ? 16'h4000 : 16'h3F80;
            b[16*i +: 16] = i[0] ? 16'h3F80 : 16'h4000;
        end
        send(OP_SLT, a, b, 1'b0);
        wait_pulse("slt", 400, lat);
        checks++;
        if (lat !== 2 * N) begin
            errors++;
            $display("FAIL slt_latency got=%0d required=%0d", lat, 2 * N);
        end
        checks++;
        if (out_data[15:0] !== 16'h0001 || out_data[31:16] !== 16'h0000) begin
            errors++;
            $display("FAIL slt_lanes01 got=%h required=00000001", out_data[31:0]);
        end
    endtask

`ifdef SNOW64_BFLOAT16_VEC_FPU_LANE_MASK_EN
    task automatic test_mask;
        int s0, lat;
        in_lane_mask = 16'h00FF;
        s0 = starts;
        send(OP_ADD, {N{16'h3F80}}, {N{16'h3F80}}, 1'b0);
        wait_pulse("mask_half", 400, lat);
        checks++;
        if (starts - s0 !== 8) begin
            errors++;
            $display("FAIL mask_half_starts got=%0d required=8", starts - s0);
        end
        in_lane_mask = '0;
        s0 = starts;
        send(OP_ADD, {N{16'h3F80}}, {N{16'h3F80}}, 1'b0);
        wait_pulse("mask_none", 100, lat);
        checks++;
        if (starts - s0 !== 0 || lat !== N) begin
            errors++;
            $display("FAIL mask_none got=%0d starts/%0d cycles required=0/%0d", starts - s0, lat, N);
        end
        in_lane_mask = '1;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_add();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_slt();
`ifdef SNOW64_BFLOAT16_VEC_FPU_LANE_MASK_EN
        test_mask();
`endif
        repeat (5) @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got=%0d required=0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
